// File: rtl/control_fsm.sv
// Multicycle accumulator-machine controller: Moore FSM with registered control outputs.
// Optional CTRL_ILLEGAL_TRAP_EN: illegal opcodes trap (sticky IllegalOp) instead of acting as NOP.
module control_fsm (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [3:0] Opcode,
  input  logic [3:0] funct,
  input  logic       Zero,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       AccWrite,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] State,
  output logic       IllegalOp
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB       = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    HALT     = 4'd10,
    TRAP     = 4'd11
  } state_t;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       mem_read;
    logic       mem_write;
    logic       acc_write;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // Control word for a state; outputs are registered from the next state so they
  // line up with State while having no combinational path from the inputs.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic zero, input logic [3:0] fn);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.ir_write  = 1'b1;
        c.mem_read  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = 2'd2;
        c.pc_source = 2'd0;
      end
      EXEC_R: begin
        c.alu_op    = fn;
        c.alu_src_b = 2'd0;
        c.acc_write = 1'b1;
      end
      EXEC_I: begin
        c.alu_op    = 4'd0;
        c.alu_src_b = 2'd1;
        c.acc_write = 1'b1;
      end
      MEM_RD:  c.mem_read = 1'b1;
      MEM_WR:  c.mem_write = 1'b1;
      WB: begin
        c.acc_write = 1'b1;
        c.alu_src_b = 2'd0;
        c.alu_op    = 4'hF;
      end
      BRANCH: begin
        c.pc_source = 2'd1;
        c.pc_write  = zero;
      end
      JUMP: begin
        c.pc_source = 2'd2;
        c.pc_write  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t state_r;
  state_t next_state_s;
  ctrl_t  ctrl_r;
  ctrl_t  ctrl_s;

  // Next-state logic.
  always_comb begin
    next_state_s = FETCH;
    case (state_r)
      FETCH: next_state_s = DECODE;
      DECODE: begin
        case (Opcode)
          4'd0:       next_state_s = EXEC_R;
          4'd1:       next_state_s = EXEC_I;
          4'd2, 4'd3: next_state_s = MEM_ADDR;
          4'd4:       next_state_s = BRANCH;
          4'd5:       next_state_s = JUMP;
          4'd15:      next_state_s = HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:    next_state_s = TRAP;
`else
          default:    next_state_s = FETCH;
`endif
        endcase
      end
      MEM_ADDR: begin
        if (Opcode == 4'd2) begin
          next_state_s = MEM_RD;
        end else if (Opcode == 4'd3) begin
          next_state_s = MEM_WR;
        end else begin
          next_state_s = FETCH;
        end
      end
      MEM_RD: next_state_s = WB;
      EXEC_R, EXEC_I, WB, MEM_WR, BRANCH, JUMP: next_state_s = FETCH;
      HALT: next_state_s = HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
      TRAP: next_state_s = TRAP;
`else
      TRAP: next_state_s = FETCH;
`endif
      default: next_state_s = FETCH;
    endcase
  end

  // Control word that will accompany the next state.
  always_comb begin
    ctrl_s = decode_ctrl(next_state_s, Zero, funct);
  end

  // State and control registers; reset loads the FETCH decode so fetch starts right after it.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r <= FETCH;
      ctrl_r  <= decode_ctrl(FETCH, 1'b0, 4'd0);
    end else begin
      state_r <= next_state_s;
      ctrl_r  <= ctrl_s;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_r;

  // Sticky flag raised on entry to TRAP, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      illegal_r <= 1'b0;
    end else if (next_state_s == TRAP) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  assign IllegalOp = illegal_r;
`else
  assign IllegalOp = 1'b0;
`endif

  assign IRWrite  = ctrl_r.ir_write;
  assign PCWrite  = ctrl_r.pc_write;
  assign MemRead  = ctrl_r.mem_read;
  assign MemWrite = ctrl_r.mem_write;
  assign AccWrite = ctrl_r.acc_write;
  assign ALUSrcB  = ctrl_r.alu_src_b;
  assign ALUOp    = ctrl_r.alu_op;
  assign PCSource = ctrl_r.pc_source;
  assign State    = state_r;

endmodule
